// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU between two valid/ready requesters.
// One operation is in flight at a time: IDLE accepts, EXEC computes, RESP holds the result.
module alu_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [3:0]  req0_aluc,
  input  logic [3:0]  req1_aluc,
  input  logic [31:0] req0_x,
  input  logic [31:0] req1_x,
  input  logic [31:0] req0_y,
  input  logic [31:0] req1_y,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp0_r,
  output logic [31:0] rsp1_r,
  output logic        rsp0_z,
  output logic        rsp1_z,
  output logic        rsp0_err,
  output logic        rsp1_err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [3:0]  op_aluc_q, op_aluc_d;
  logic [31:0] op_x_q, op_x_d;
  logic [31:0] op_y_q, op_y_d;
  logic [31:0] res_r_q, res_r_d;
  logic        res_z_q, res_z_d;
  logic        res_err_q, res_err_d;

  logic        grant0, grant1;
  logic [31:0] alu_r;
  logic        alu_err;
  logic [4:0]  sa;
  logic        rsp_hs;

  // On a tie, RR favours whoever was not served last; fixed priority always favours port 0.
  assign grant0 = req0_valid & (~req1_valid | ~RR | last_grant_q);
  assign grant1 = req1_valid & ~grant0;

  assign sa = op_x_q[10:6];

  always_comb begin
    alu_r   = '0;
    alu_err = 1'b0;
    case (op_aluc_q)
      4'b0000: alu_r = op_x_q + op_y_q;
      4'b0001: alu_r = op_x_q - op_y_q;
      4'b0010: alu_r = op_x_q & op_y_q;
      4'b0011: alu_r = op_x_q | op_y_q;
      4'b0100: alu_r = op_x_q ^ op_y_q;
      4'b0110: alu_r = {op_y_q[15:0], 16'h0000};
      // 0111 lands on the left shifter through the ALU's shift-control wiring.
      4'b0101, 4'b0111, 4'b1101: alu_r = op_y_q << sa;
      4'b1111: alu_r = 32'($signed(op_y_q) >>> sa);
      default: alu_err = 1'b1;
    endcase
  end

  assign rsp_hs = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_aluc_d    = op_aluc_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    res_r_d      = res_r_q;
    res_z_d      = res_z_q;
    res_err_d    = res_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (req0_valid && grant0) begin
          owner_d   = 1'b0;
          op_aluc_d = req0_aluc;
          op_x_d    = req0_x;
          op_y_d    = req0_y;
          state_d   = StExec;
        end else if (req1_valid && grant1) begin
          owner_d   = 1'b1;
          op_aluc_d = req1_aluc;
          op_x_d    = req1_x;
          op_y_d    = req1_y;
          state_d   = StExec;
        end
      end
      StExec: begin
        res_r_d   = alu_err ? 32'h0 : alu_r;
        res_z_d   = alu_err ? 1'b1 : (alu_r == 32'h0);
        res_err_d = alu_err;
        state_d   = StResp;
      end
      StResp: begin
        if (rsp_hs) begin
          last_grant_d = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_aluc_q    <= '0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      res_r_q      <= '0;
      res_z_q      <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_aluc_q    <= op_aluc_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      res_r_q      <= res_r_d;
      res_z_q      <= res_z_d;
      res_err_q    <= res_err_d;
    end
  end

  assign rsp0_valid = (state_q == StResp) & ~owner_q;
  assign rsp1_valid = (state_q == StResp) & owner_q;
  assign rsp0_r     = res_r_q;
  assign rsp1_r     = res_r_q;
  assign rsp0_z     = res_z_q;
  assign rsp1_z     = res_z_q;
  assign rsp0_err   = res_err_q;
  assign rsp1_err   = res_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: RR=1 and RR=0 instances share stimulus, one is observed.
module tb_alu_arbiter;

  typedef struct packed {logic [3:0] aluc; logic [31:0] x; logic [31:0] y;} op_t;
  typedef struct packed {logic port; logic [31:0] r; logic z; logic err;} exp_t;

  logic        clk, clrn, sel_fp;
  logic        req0_valid, req1_valid, rsp_rdy0, rsp_rdy1;
  logic [3:0]  req0_aluc, req1_aluc;
  logic [31:0] req0_x, req1_x, req0_y, req1_y;

  logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid;
  logic        a_rsp0_z, a_rsp1_z, a_rsp0_err, a_rsp1_err;
  logic [31:0] a_rsp0_r, a_rsp1_r;
  logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
  logic        b_rsp0_z, b_rsp1_z, b_rsp0_err, b_rsp1_err;
  logic [31:0] b_rsp0_r, b_rsp1_r;

  logic        m_req0_ready, m_req1_ready, m_rsp0_valid, m_rsp1_valid;
  logic        m_rsp0_z, m_rsp1_z, m_rsp0_err, m_rsp1_err;
  logic [31:0] m_rsp0_r, m_rsp1_r;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  op_t  ops0[8];
  op_t  ops1[8];

  alu_arbiter #(.RR(1'b1)) dut_a (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(a_req0_ready), .req1_ready(a_req1_ready),
    .req0_aluc(req0_aluc), .req1_aluc(req1_aluc),
    .req0_x(req0_x), .req1_x(req1_x), .req0_y(req0_y), .req1_y(req1_y),
    .rsp0_valid(a_rsp0_valid), .rsp1_valid(a_rsp1_valid),
    .rsp0_ready(sel_fp ? 1'b1 : rsp_rdy0), .rsp1_ready(sel_fp ? 1'b1 : rsp_rdy1),
    .rsp0_r(a_rsp0_r), .rsp1_r(a_rsp1_r), .rsp0_z(a_rsp0_z), .rsp1_z(a_rsp1_z),
    .rsp0_err(a_rsp0_err), .rsp1_err(a_rsp1_err)
  );

  alu_arbiter #(.RR(1'b0)) dut_b (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
    .req0_aluc(req0_aluc), .req1_aluc(req1_aluc),
    .req0_x(req0_x), .req1_x(req1_x), .req0_y(req0_y), .req1_y(req1_y),
    .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid),
    .rsp0_ready(sel_fp ? rsp_rdy0 : 1'b1), .rsp1_ready(sel_fp ? rsp_rdy1 : 1'b1),
    .rsp0_r(b_rsp0_r), .rsp1_r(b_rsp1_r), .rsp0_z(b_rsp0_z), .rsp1_z(b_rsp1_z),
    .rsp0_err(b_rsp0_err), .rsp1_err(b_rsp1_err)
  );

  assign m_req0_ready = sel_fp ? b_req0_ready : a_req0_ready;
  assign m_req1_ready = sel_fp ? b_req1_ready : a_req1_ready;
  assign m_rsp0_valid = sel_fp ? b_rsp0_valid : a_rsp0_valid;
  assign m_rsp1_valid = sel_fp ? b_rsp1_valid : a_rsp1_valid;
  assign m_rsp0_r     = sel_fp ? b_rsp0_r : a_rsp0_r;
  assign m_rsp1_r     = sel_fp ? b_rsp1_r : a_rsp1_r;
  assign m_rsp0_z     = sel_fp ? b_rsp0_z : a_rsp0_z;
  assign m_rsp1_z     = sel_fp ? b_rsp1_z : a_rsp1_z;
  assign m_rsp0_err   = sel_fp ? b_rsp0_err : a_rsp0_err;
  assign m_rsp1_err   = sel_fp ? b_rsp1_err : a_rsp1_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic port, input logic [31:0] r, input logic err);
    exp_t e;
    e.port = port;
    e.r    = r;
    e.z    = (r == 32'h0);
    e.err  = err;
    return e;
  endfunction

  // Monitor: pops one expected entry per observed response handshake.
  initial begin
    exp_t e;
    logic hs, port;
    forever begin
      @(negedge clk);
      #2;
      if (m_rsp0_valid || m_rsp1_valid)
        check("rsp_both_valid", 32'(m_rsp0_valid & m_rsp1_valid), 32'h0);
      hs   = (m_rsp0_valid && rsp_rdy0) || (m_rsp1_valid && rsp_rdy1);
      port = m_rsp1_valid;
      if (hs) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(port), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("rsp_port", 32'(port), 32'(e.port));
          check("rsp_r", port ? m_rsp1_r : m_rsp0_r, e.r);
          check("rsp_z", 32'(port ? m_rsp1_z : m_rsp0_z), 32'(e.z));
          check("rsp_err", 32'(port ? m_rsp1_err : m_rsp0_err), 32'(e.err));
        end
      end
    end
  end

  // Presents ops0[0..n0-1] / ops1[0..n1-1] with valid held until each is accepted.
  task automatic run(input int n0, input int n1);
    int i0 = 0, i1 = 0, c0 = 0, c1 = 0, cyc = 0;
    logic a0, a1;
    while ((i0 < n0 || i1 < n1) && cyc < 200) begin
      @(negedge clk);
      req0_valid = (i0 < n0);
      req1_valid = (i1 < n1);
      if (i0 < n0) {req0_aluc, req0_x, req0_y} = ops0[i0];
      if (i1 < n1) {req1_aluc, req1_x, req1_y} = ops1[i1];
      #1;
      a0 = req0_valid && m_req0_ready;
      a1 = req1_valid && m_req1_ready;
      if (a0) c0++;
      if (a1) c1++;
      @(posedge clk);
      if (a0) i0++;
      if (a1) i1++;
      cyc++;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("accept0_count", 32'(c0), 32'(n0));
    check("accept1_count", 32'(c1), 32'(n1));
  endtask

  task automatic drain();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_empty", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    logic got;
    clrn = 1'b0; sel_fp = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_rdy0 = 1'b1; rsp_rdy1 = 1'b1;
    req0_aluc = '0; req1_aluc = '0; req0_x = '0; req1_x = '0; req0_y = '0; req1_y = '0;
    #12;
    check("rst_rsp0_valid", 32'(m_rsp0_valid), 32'h0);
    check("rst_rsp1_valid", 32'(m_rsp1_valid), 32'h0);
    check("rst_rsp_r", m_rsp0_r, 32'h0);
    check("rst_rsp_err", 32'(m_rsp1_err), 32'h0);
    @(negedge clk);
    clrn = 1'b1;

    // add with latency check
    @(negedge clk);
    req0_valid = 1'b1; req0_aluc = 4'b0000; req0_x = 32'd5; req0_y = 32'd7;
    sb.push_back(mk(1'b0, 32'd12, 1'b0));
    #1;
    check("add_ready0", 32'(m_req0_ready), 32'h1);
    check("add_ready1", 32'(m_req1_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("add_exec_valid0", 32'(m_rsp0_valid), 32'h0);
    @(negedge clk);
    #1;
    check("add_resp_valid0", 32'(m_rsp0_valid), 32'h1);
    check("add_resp_valid1", 32'(m_rsp1_valid), 32'h0);
    drain();

    // sub then sra on port 1
    ops1[0] = '{4'b0001, 32'h7, 32'h7};
    ops1[1] = '{4'b1111, 32'h100, 32'h8000_0000};
    sb.push_back(mk(1'b1, 32'h0, 1'b0));
    sb.push_back(mk(1'b1, 32'hF800_0000, 1'b0));
    run(0, 2);
    drain();

    // both valid, four ops each
    ops0[0] = '{4'b0000, 32'h1, 32'h1};
    ops0[1] = '{4'b0011, 32'hF0, 32'h0F};
    ops0[2] = '{4'b0100, 32'hFF, 32'hFF};
    ops0[3] = '{4'b0110, 32'h0, 32'h1234};
    ops1[0] = '{4'b0010, 32'hFF00, 32'h0FF0};
    ops1[1] = '{4'b0101, 32'h40, 32'h3};
    ops1[2] = '{4'b0111, 32'h200, 32'h1};
    ops1[3] = '{4'b1101, 32'h7C0, 32'h1};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(1'b0, (i == 0) ? 32'h2 : (i == 1) ? 32'hFF : (i == 2) ? 32'h0 :
                   32'h1234_0000, 1'b0));
      sb.push_back(mk(1'b1, (i == 0) ? 32'h0F00 : (i == 1) ? 32'h6 : (i == 2) ? 32'h100 :
                   32'h8000_0000, 1'b0));
    end
    run(4, 4);
    drain();

    // backpressure with a pending port-1 request
    rsp_rdy0 = 1'b0;
    ops0[0] = '{4'b0000, 32'h10, 32'h20};
    sb.push_back(mk(1'b0, 32'h30, 1'b0));
    run(1, 0);
    req1_valid = 1'b1; req1_aluc = 4'b0011; req1_x = 32'h1; req1_y = 32'h2;
    sb.push_back(mk(1'b1, 32'h3, 1'b0));
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_valid", 32'(m_rsp0_valid), 32'h1);
      check("bp_r", m_rsp0_r, 32'h30);
      check("bp_z", 32'(m_rsp0_z), 32'h0);
      check("bp_ready0", 32'(m_req0_ready), 32'h0);
      check("bp_ready1", 32'(m_req1_ready), 32'h0);
    end
    @(negedge clk);
    rsp_rdy0 = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      #1;
      got = m_req1_ready;
    end
    check("bp_req1_accept", 32'(got), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    drain();

    // illegal code then a legal op
    ops0[0] = '{4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ops0[1] = '{4'b0000, 32'hFFFF_FFFF, 32'h1};
    sb.push_back(mk(1'b0, 32'h0, 1'b1));
    sb.push_back(mk(1'b0, 32'h0, 1'b0));
    run(2, 0);
    drain();

    // fixed priority instance: all port-0 ops before port-1
    @(negedge clk);
    clrn = 1'b0;
    sel_fp = 1'b1;
    @(negedge clk);
    clrn = 1'b1;
    ops0[0] = '{4'b0000, 32'h1, 32'h1};
    ops0[1] = '{4'b0011, 32'hF0, 32'h0F};
    ops0[2] = '{4'b0100, 32'hFF, 32'hFF};
    ops0[3] = '{4'b0110, 32'h0, 32'h1234};
    sb.push_back(mk(1'b0, 32'h2, 1'b0));
    sb.push_back(mk(1'b0, 32'hFF, 1'b0));
    sb.push_back(mk(1'b0, 32'h0, 1'b0));
    sb.push_back(mk(1'b0, 32'h1234_0000, 1'b0));
    sb.push_back(mk(1'b1, 32'h0F00, 1'b0));
    sb.push_back(mk(1'b1, 32'h6, 1'b0));
    sb.push_back(mk(1'b1, 32'h100, 1'b0));
    sb.push_back(mk(1'b1, 32'h8000_0000, 1'b0));
    run(4, 4);
    drain();

    // reset during EXEC discards the op
    @(negedge clk);
    sel_fp = 1'b0;
    req0_valid = 1'b1; req0_aluc = 4'b0000; req0_x = 32'd3; req0_y = 32'd4;
    #1;
    check("rst_op_ready0", 32'(m_req0_ready), 32'h1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    #1;
    clrn = 1'b0;
    #1;
    check("mid_rst_valid0", 32'(m_rsp0_valid), 32'h0);
    check("mid_rst_valid1", 32'(m_rsp1_valid), 32'h0);
    check("mid_rst_r", m_rsp0_r, 32'h0);
    check("mid_rst_z", 32'(m_rsp0_z), 32'h0);
    check("mid_rst_err", 32'(m_rsp0_err), 32'h0);
    check("mid_rst_ready0", 32'(m_req0_ready), 32'h0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (6) @(negedge clk);
    ops0[0] = '{4'b0010, 32'hF0F0, 32'hFF00};
    ops1[0] = '{4'b0000, 32'h10, 32'h1};
    sb.push_back(mk(1'b0, 32'hF000, 1'b0));
    sb.push_back(mk(1'b1, 32'h11, 1'b0));
    run(1, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
